// File: rtl/bmem_arbiter.sv
// bmem_arbiter: shares one 64-bit burst memory port between the icache and dcache line ports.
// Round-robin grant, one transaction outstanding, lines moved as BEATS-beat bursts.
module bmem_arbiter #(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned BEAT_BITS = 64,
    parameter int unsigned BEATS     = LINE_BITS / BEAT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          i_dfp_addr,
    input  logic                 i_dfp_read,
    output logic [LINE_BITS-1:0] i_dfp_rdata,
    output logic                 i_dfp_resp,
    input  logic [31:0]          d_dfp_addr,
    input  logic                 d_dfp_read,
    input  logic                 d_dfp_write,
    input  logic [LINE_BITS-1:0] d_dfp_wdata,
    output logic [LINE_BITS-1:0] d_dfp_rdata,
    output logic                 d_dfp_resp,
    output logic [31:0]          bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_BITS-1:0] bmem_wdata,
    input  logic                 bmem_ready,
    input  logic [31:0]          bmem_raddr,
    input  logic [BEAT_BITS-1:0] bmem_rdata,
    input  logic                 bmem_rvalid
);

    localparam int unsigned      CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [31:0]      ALIGN_MASK = ~(32'(LINE_BITS / 8) - 32'd1);

    typedef enum logic [2:0] {
        StIdle,
        StRdCmd,
        StRdData,
        StWrData,
        StResp
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          addr_q, addr_d;
    logic [LINE_BITS-1:0] line_q, line_d;
    logic                 owner_q, owner_d;    // 1: dcache owns the transaction
    logic                 prefer_q, prefer_d;  // 1: dcache wins the next tie
    logic                 grant_d;
    logic                 d_req;

    logic                 bmem_read_q, bmem_read_d;
    logic                 bmem_write_q, bmem_write_d;
    logic [31:0]          bmem_addr_q, bmem_addr_d;
    logic [BEAT_BITS-1:0] bmem_wdata_q, bmem_wdata_d;
    logic                 i_resp_q, i_resp_d;
    logic                 d_resp_q, d_resp_d;
    logic [LINE_BITS-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_BITS-1:0] d_rdata_q, d_rdata_d;

    assign d_req = d_dfp_read | d_dfp_write;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        line_d       = line_q;
        owner_d      = owner_q;
        prefer_d     = prefer_q;
        grant_d      = 1'b0;
        bmem_read_d  = 1'b0;
        bmem_write_d = 1'b0;
        bmem_addr_d  = bmem_addr_q;
        bmem_wdata_d = bmem_wdata_q;
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (d_req || i_dfp_read) begin
                    grant_d     = d_req && (!i_dfp_read || prefer_q);
                    owner_d     = grant_d;
                    prefer_d    = !grant_d;
                    addr_d      = (grant_d ? d_dfp_addr : i_dfp_addr) & ALIGN_MASK;
                    bmem_addr_d = addr_d;
                    cnt_d       = '0;
                    // A dcache writeback takes priority over its own read request
                    if (grant_d && d_dfp_write) begin
                        line_d       = d_dfp_wdata;
                        bmem_write_d = 1'b1;
                        bmem_wdata_d = d_dfp_wdata[BEAT_BITS-1:0];
                        state_d      = StWrData;
                    end else begin
                        bmem_read_d = 1'b1;
                        state_d     = StRdCmd;
                    end
                end
            end

            StRdCmd: begin
                bmem_read_d = 1'b1;
                if (bmem_ready) begin
                    bmem_read_d = 1'b0;
                    state_d     = StRdData;
                end
            end

            StRdData: begin
                if (bmem_rvalid && (bmem_raddr == addr_q)) begin
                    line_d[int'(cnt_q) * BEAT_BITS +: BEAT_BITS] = bmem_rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = StResp;
                        if (owner_q) begin
                            d_resp_d  = 1'b1;
                            d_rdata_d = line_d;
                        end else begin
                            i_resp_d  = 1'b1;
                            i_rdata_d = line_d;
                        end
                    end
                end
            end

            StWrData: begin
                bmem_write_d = 1'b1;
                if (bmem_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        bmem_write_d = 1'b0;
                        state_d      = StResp;
                        d_resp_d     = owner_q;
                        i_resp_d     = !owner_q;
                    end else begin
                        cnt_d        = cnt_q + CNT_W'(1);
                        bmem_wdata_d = line_q[int'(cnt_d) * BEAT_BITS +: BEAT_BITS];
                    end
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            addr_q       <= '0;
            line_q       <= '0;
            owner_q      <= 1'b0;
            prefer_q     <= 1'b1;
            bmem_read_q  <= 1'b0;
            bmem_write_q <= 1'b0;
            bmem_addr_q  <= '0;
            bmem_wdata_q <= '0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
            owner_q      <= owner_d;
            prefer_q     <= prefer_d;
            bmem_read_q  <= bmem_read_d;
            bmem_write_q <= bmem_write_d;
            bmem_addr_q  <= bmem_addr_d;
            bmem_wdata_q <= bmem_wdata_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bmem_read   = bmem_read_q;
    assign bmem_write  = bmem_write_q;
    assign bmem_addr   = bmem_addr_q;
    assign bmem_wdata  = bmem_wdata_q;
    assign i_dfp_resp  = i_resp_q;
    assign d_dfp_resp  = d_resp_q;
    assign i_dfp_rdata = i_rdata_q;
    assign d_dfp_rdata = d_rdata_q;

endmodule
